// File: rtl/count_sequence_decoder.sv
// Receiver for a two-bit 0-1-2-3 counter on two asynchronous lines: synchronises,
// validates increments, locks after a run of legal steps and reports errors/stalls.
module count_sequence_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STEPS  = 4,
  parameter int TIMEOUT     = 64,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             clr_err,
  output logic [1:0]       count,
  output logic             locked,
  output logic             step,
  output logic             wrap,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             stalled
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [0:0] ACQUIRE = 1'b0;
  localparam logic [0:0] TRACK   = 1'b1;

  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [1:0]             s, prev;
  logic [0:0]             state;
  logic [3:0]             run;
  logic [IDLE_W-1:0]      idle;
  logic                   change, legal, illegal, timeout, err_event;

  // NOTE: every flop, including the synchroniser chain, takes the async reset so
  // the receiver always restarts from a known prev = 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      prev   <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value.
      sync_a <= {sync_a[SYNC_STAGES-2:0], in_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], in_b};
      prev   <= s;
    end
  end

  assign s         = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
  assign count     = prev;
  assign change    = (s != prev);
  assign legal     = (s == 2'(prev + 2'd1));
  assign illegal   = change && !legal;
  assign timeout   = !change && (idle == IDLE_W'(TIMEOUT - 1));
  assign locked    = (state == TRACK);
  assign err_event = (state == TRACK) && illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACQUIRE;
      run   <= 4'd0;
      step  <= 1'b0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
      case (state)
        ACQUIRE: begin
          // The locking increment itself is not reported as a step.
          if (legal) begin
            if (run == 4'(LOCK_STEPS - 1)) begin
              state <= TRACK;
              run   <= 4'd0;
            end else begin
              run <= run + 4'd1;
            end
          end else if (illegal) begin
            run <= 4'd0;
          end
        end
        TRACK: begin
          if (legal) begin
            step <= 1'b1;
            wrap <= (prev == 2'd3);
          end else if (illegal) begin
            err   <= 1'b1;
            state <= ACQUIRE;
            run   <= 4'd0;
          end else if (timeout) begin
            state <= ACQUIRE;
            run   <= 4'd0;
          end
        end
        default: begin
          state <= ACQUIRE;
          run   <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle    <= '0;
      err_cnt <= '0;
      stalled <= 1'b0;
    end else begin
      if (change)
        idle <= '0;
      else if (idle != IDLE_W'(TIMEOUT))
        idle <= idle + 1'b1;

      // A clear coinciding with an error leaves exactly that error counted.
      if (clr_err)
        err_cnt <= err_event ? ERR_W'(1) : '0;
      else if (err_event && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;

      if (timeout)
        stalled <= 1'b1;
      else if (clr_err)
        stalled <= 1'b0;
    end
  end

endmodule

// File: tb/tb_count_sequence_decoder.sv
// Randomised self-checking bench for count_sequence_decoder, scored against a
// per-transition reference model of the count protocol.
module tb_count_sequence_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int LOCK_STEPS  = 4;
  localparam int TIMEOUT     = 64;
  localparam int ERR_W       = 2;
  localparam int ERR_MAX     = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_a = 1'b0;
  logic             in_b = 1'b0;
  logic             clr_err = 1'b0;
  logic [1:0]       count;
  logic             locked, step, wrap, err, stalled;
  logic [ERR_W-1:0] err_cnt;

  count_sequence_decoder #(
    .SYNC_STAGES(SYNC_STAGES), .LOCK_STEPS(LOCK_STEPS),
    .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .clr_err(clr_err),
    .count(count), .locked(locked), .step(step), .wrap(wrap), .err(err),
    .err_cnt(err_cnt), .stalled(stalled)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse tallies observed on the falling edge.
  int step_seen = 0, wrap_seen = 0, err_seen = 0;
  always @(negedge clk) begin
    if (step) step_seen <= step_seen + 1;
    if (wrap) wrap_seen <= wrap_seen + 1;
    if (err)  err_seen  <= err_seen + 1;
  end

  // Reference model: one call per code presented on the inputs.
  int m_count = 0, m_run = 0, m_err_cnt = 0;
  int exp_step = 0, exp_wrap = 0, exp_err = 0;
  bit m_locked = 0, m_stalled = 0;

  function automatic void model_change(int code, bit clr);
    int d;
    bit e;
    d = (code - m_count + 4) % 4;
    e = 0;
    if (d != 0) begin
      if (m_locked) begin
        if (d == 1) begin
          exp_step++;
          if (m_count == 3) exp_wrap++;
        end else begin
          e = 1;
          exp_err++;
          m_locked = 0;
          m_run = 0;
        end
      end else if (d == 1) begin
        m_run++;
        if (m_run == LOCK_STEPS) begin
          m_locked = 1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    if (clr) begin
      m_err_cnt = e ? 1 : 0;
      m_stalled = 0;
    end else if (e && m_err_cnt < ERR_MAX) begin
      m_err_cnt++;
    end
    m_count = code;
  endfunction

  function automatic void model_reset();
    m_count = 0; m_run = 0; m_err_cnt = 0; m_locked = 0; m_stalled = 0;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(int code, int hold);
    {in_a, in_b} = 2'(code);
    model_change(code, 1'b0);
    repeat (hold) tick();
  endtask

  task automatic relock();
    for (int i = 0; i < 12 && !m_locked; i++) drive((m_count + 1) % 4, 8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({count, locked, step, wrap, err, err_cnt, stalled} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got count=%0d locked=%b step=%b wrap=%b err=%b err_cnt=%0d stalled=%b, want all zero",
               count, locked, step, wrap, err, err_cnt, stalled);
    end
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_lock();
    drive(1, 8);
    drive(2, 8);
    drive(3, 8);
    {in_a, in_b} = 2'd0;
    model_change(0, 1'b0);
    tick();
    tick();
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_early: locked=%b, want 0 one cycle before lock", locked);
    end
    tick();
    n_checks++;
    if (locked !== 1'b1 || step !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_rise: locked=%b step=%b, want locked=1 step=0", locked, step);
    end
    repeat (5) tick();
    drive(1, 8);
    drive(2, 8);
    drive(3, 8);
    drive(0, 8);
    n_checks++;
    if (step_seen != exp_step || wrap_seen != exp_wrap || exp_wrap != 1 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL lock_steps: steps=%0d wraps=%0d err_cnt=%0d, want steps=%0d wraps=%0d err_cnt=0",
               step_seen, wrap_seen, err_cnt, exp_step, exp_wrap);
    end
  endtask

  task automatic test_latency();
    drive(1, 8);
    {in_a, in_b} = 2'd2;
    model_change(2, 1'b0);
    for (int c = 1; c <= SYNC_STAGES + 1; c++) begin
      tick();
      n_checks++;
      if (step !== (c == SYNC_STAGES + 1) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL latency_c%0d: step=%b err=%b, want step=%b err=0", c, step, err, c == SYNC_STAGES + 1);
      end
    end
    n_checks++;
    if (count !== 2'd2 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL double_flip: count=%0d locked=%b, want count=2 locked=1", count, locked);
    end
    repeat (5) tick();
  endtask

  task automatic test_skip_error();
    drive(3, 8);
    drive(0, 8);
    drive(1, 8);
    {in_a, in_b} = 2'd3;
    model_change(3, 1'b0);
    tick();
    tick();
    n_checks++;
    if (locked !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_pre: locked=%b err=%b, want locked=1 err=0", locked, err);
    end
    tick();
    n_checks++;
    if (err !== 1'b1 || locked !== 1'b0 || step !== 1'b0 || count !== 2'd3) begin
      n_fail++;
      $display("FAIL skip_err: err=%b locked=%b step=%b count=%0d, want err=1 locked=0 step=0 count=3",
               err, locked, step, count);
    end
    repeat (5) tick();
    n_checks++;
    if (err_cnt !== 2'd1 || err_seen != exp_err) begin
      n_fail++;
      $display("FAIL skip_cnt: err_cnt=%0d errs=%0d, want err_cnt=1 errs=%0d", err_cnt, err_seen, exp_err);
    end
    relock();
    n_checks++;
    if (locked !== 1'b1 || !m_locked) begin
      n_fail++;
      $display("FAIL skip_relock: locked=%b, want 1", locked);
    end
  endtask

  task automatic test_stall();
    int w, k;
    bit early;
    logic [ERR_W-1:0] cnt_before;
    cnt_before = err_cnt;
    {in_a, in_b} = 2'((m_count + 1) % 4);
    model_change((m_count + 1) % 4, 1'b0);
    w = 0;
    while (!step && w < 10) begin tick(); w++; end
    n_checks++;
    if (step !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_step: no step within %0d cycles", w);
    end
    k = 0;
    early = 0;
    while (!stalled && k < 100) begin
      tick();
      k++;
      if (!stalled && !locked) early = 1;
    end
    m_locked = 0; m_run = 0; m_stalled = 1;
    n_checks++;
    if (k != TIMEOUT || early || locked !== 1'b0 || err_cnt !== cnt_before) begin
      n_fail++;
      $display("FAIL stall_timeout: cycles=%0d early_drop=%b locked=%b err_cnt=%0d, want cycles=%0d early_drop=0 locked=0 err_cnt=%0d",
               k, early, locked, err_cnt, TIMEOUT, cnt_before);
    end
    drive((m_count + 1) % 4, 8);
    n_checks++;
    if (stalled !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_sticky: stalled=%b, want 1", stalled);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    m_err_cnt = 0; m_stalled = 0;
    n_checks++;
    if (stalled !== 1'b0 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL stall_clear: stalled=%b err_cnt=%0d, want 0 and 0", stalled, err_cnt);
    end
  endtask

  task automatic test_saturation();
    int code;
    repeat (5) begin
      relock();
      drive((m_count + 2) % 4, 8);
    end
    n_checks++;
    if (err_cnt !== 2'(ERR_MAX) || err_seen != exp_err || m_err_cnt != ERR_MAX) begin
      n_fail++;
      $display("FAIL sat_cnt: err_cnt=%0d errs=%0d, want err_cnt=%0d errs=%0d", err_cnt, err_seen, ERR_MAX, exp_err);
    end
    relock();
    code = (m_count + 2) % 4;
    {in_a, in_b} = 2'(code);
    model_change(code, 1'b1);
    tick();
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_prio_err: err=%b, want 1", err);
    end
    repeat (3) tick();
    n_checks++;
    if (err_cnt !== 2'(m_err_cnt) || m_err_cnt != 1) begin
      n_fail++;
      $display("FAIL clr_prio_cnt: err_cnt=%0d, want 1", err_cnt);
    end
  endtask

  task automatic test_random();
    int r, code;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      code = (m_count + 1) % 4;
      else if (r < 8) code = (m_count + 2) % 4;
      else if (r < 9) code = (m_count + 3) % 4;
      else            code = m_count;
      drive(code, $urandom_range(4, 12));
      n_checks++;
      if ({locked, count, err_cnt, stalled} !== {m_locked, 2'(m_count), ERR_W'(m_err_cnt), m_stalled}) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: locked=%b count=%0d err_cnt=%0d stalled=%b, want %b %0d %0d %b",
                 i, locked, count, err_cnt, stalled, m_locked, m_count, m_err_cnt, m_stalled);
      end
      n_checks++;
      if (step_seen != exp_step || wrap_seen != exp_wrap || err_seen != exp_err) begin
        n_fail++;
        $display("FAIL rand_pulses[%0d]: step=%0d wrap=%0d err=%0d, want %0d %0d %0d",
                 i, step_seen, wrap_seen, err_seen, exp_step, exp_wrap, exp_err);
      end
    end
  endtask

  task automatic test_async_reset();
    relock();
    drive((m_count + 2) % 4, 8);
    relock();
    drive((m_count + 1) % 4, 8);
    n_checks++;
    if (locked !== 1'b1 || err_cnt === 0 || count === 2'd0) begin
      n_fail++;
      $display("FAIL areset_pre: locked=%b err_cnt=%0d count=%0d, want locked=1 nonzero err_cnt/count",
               locked, err_cnt, count);
    end
    #2;
    rst = 1'b1;
    {in_a, in_b} = 2'd0;
    #1;
    n_checks++;
    if (count !== 2'd0 || locked !== 1'b0 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL areset_async: count=%0d locked=%b err_cnt=%0d, want all zero", count, locked, err_cnt);
    end
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    drive(1, 8);
    drive(2, 8);
    drive(3, 8);
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_early: locked=%b after 3 steps, want 0", locked);
    end
    drive(0, 8);
    n_checks++;
    if (locked !== 1'b1 || count !== 2'd0 || !m_locked) begin
      n_fail++;
      $display("FAIL areset_relock: locked=%b count=%0d, want locked=1 count=0", locked, count);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_latency();
    test_skip_error();
    test_stall();
    test_saturation();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/count_sequence_decoder.md
Name: count_sequence_decoder

Overview:
- Receiver for the two-bit count outputs (A/B lines) of the two-bit counter/clock-divider block.
- Synchronises both lines into the local clock and reconstructs the 0-1-2-3 count.
- Validates the sequence, locks after a run of legal increments, and flags skips, reversals and stalls.
- Sits on the consumer side of the counter, feeding status and a step/wrap event stream to downstream logic.

Parameters:
- SYNC_STAGES, 2, flops per input line in the synchroniser (minimum 2).
- LOCK_STEPS, 4, consecutive legal increments required to enter TRACK (1..15).
- TIMEOUT, 64, cycles without any input change before stall is flagged (≥ 2).
- ERR_W, 8, width of saturating error counter.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- in_a  in  1  count bit 1 (MSB) from counter outA; asynchronous to clk.
- in_b  in  1  count bit 0 (LSB) from counter outB; asynchronous to clk.
- clr_err  in  1  synchronous clear of err_cnt and stalled.
- count  out  2  last accepted code {a,b}.
- locked  out  1  high in TRACK.
- step  out  1  one-cycle pulse per legal increment while locked.
- wrap  out  1  one-cycle pulse on legal 3->0 while locked (coincident with step).
- err  out  1  one-cycle pulse on illegal transition while locked.
- err_cnt  out  ERR_W  saturating count of err pulses.
- stalled  out  1  sticky: no input change for TIMEOUT cycles.

Behaviour:
- Reset (async assert, sync release): synchroniser flops = 0, prev code = 0, count = 0, locked = 0, step/wrap/err = 0, err_cnt = 0, stalled = 0, run counter = 0, idle timer = 0, FSM = ACQUIRE.
- Sampled code s = {sync(in_a), sync(in_b)}. change = (s != prev). prev <= s every cycle. count = prev.
- Legal transition: s == prev+1 mod 4, including 01->10 and 11->00 where both bits flip together. Any other change (+2, -1) is illegal.
- Latency: input edge to step/err pulse = SYNC_STAGES+1 clk cycles.
- ACQUIRE:
  - locked = 0; step/wrap/err are never asserted.
  - Legal change: run++.
  - Illegal change: run = 0.
  - When run reaches LOCK_STEPS on a legal change: enter TRACK next cycle and clear run. That change does not pulse step.
- TRACK:
  - locked = 1.
  - Legal change: step = 1; wrap = 1 if prev == 3.
  - Illegal change: err = 1, err_cnt++ (saturating at all-ones), run = 0, and return to ACQUIRE next cycle. locked drops the same cycle err pulses.
- Idle timer:
  - Cleared on any change, otherwise increments (saturating).
  - Reaching TIMEOUT sets stalled in either state.
  - In TRACK, a timeout also forces ACQUIRE (locked drops) without an err pulse.
  - stalled stays set until clr_err or reset; a later input change does not clear it.
- clr_err:
  - Clears err_cnt and stalled next cycle.
  - If an error occurs in the same cycle, err still pulses and err_cnt becomes 1.
  - If a timeout occurs in the same cycle, stalled ends up 1.
- Reset mid-TRACK: all outputs return to reset values immediately (asynchronous). Relock requires LOCK_STEPS legal changes measured from prev = 0.
- No change: no pulses; count holds.

Test Plan:
- Lock: reset, then drive counter sequence 0,1,2,3,0,1 with 8 clk per code -> locked rises 1 cycle after the 4th legal change reaches sync output. Then step pulses on each later change, wrap only on 3->0, err_cnt = 0.
- Latency/double-flip: while locked, drive 01->10 -> step pulses exactly SYNC_STAGES+1 = 3 cycles after the input edge, count = 2, no err.
- Skip error: while locked at count = 1, drive 3 -> err pulse, err_cnt = 1, locked = 0 the same cycle, no step. Then 4 legal steps -> relock.
- Stall: while locked, hold inputs for 70 cycles -> stalled = 1 and locked = 0 at cycle TIMEOUT after the last change, err_cnt unchanged. clr_err -> stalled = 0.
- Saturation/clear priority: with ERR_W = 2, force 5 errors (relocking between each) -> err_cnt sticks at 3. Then assert clr_err in the cycle of an error -> err_cnt = 1.
- Async reset mid-TRACK: assert rst between clk edges -> count, locked and err_cnt go to 0 before the next edge. After release, 0,1,2,3,0 relocks.
